// File: rtl/rob_pkg.sv
// Shared constants and entry type for the reorder buffer (rob).
// Build option: ROB_COMMIT_BYPASS_EN (see rob.sv).
package rob_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int ROB_IDX_W = 5;
    localparam int ROB_CNT_W = 6;
    localparam int XLEN      = 32;

    localparam logic [ROB_CNT_W-1:0] ROB_FULL_CNT  = 6'd32;
    localparam logic [ROB_CNT_W-1:0] ROB_EMPTY_CNT = 6'd0;

    // View of one buffer slot as seen at the head for retirement.
    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      inst;
        logic [ROB_IDX_W-1:0] prd_addr;
        logic [XLEN-1:0]      value;
    } rob_entry_t;

    // Advance a circular pointer; the 5-bit width gives the wrap 31 -> 0.
    function automatic logic [ROB_IDX_W-1:0] ptr_inc(input logic [ROB_IDX_W-1:0] ptr);
        return ptr + 5'd1;
    endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer.
// Decides whether an allocation is accepted and derives full/empty.
module rob_ptr_ctrl
    import rob_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 alloc_req_i,
    input  logic                 commit_i,
    output logic                 alloc_fire_o,
    output logic [ROB_IDX_W-1:0] head_o,
    output logic [ROB_IDX_W-1:0] tail_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [ROB_IDX_W-1:0] r_head;
    logic [ROB_IDX_W-1:0] r_tail;
    logic [ROB_CNT_W-1:0] r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_alloc_fire;

    // Occupancy flags and allocation acceptance from registered state; a
    // request while full is dropped even if the head retires this cycle.
    always_comb begin
        w_full       = (r_count == ROB_FULL_CNT);
        w_empty      = (r_count == ROB_EMPTY_CNT);
        w_alloc_fire = alloc_req_i & ~w_full;
    end

    // Pointer and occupancy registers; reset wins over any request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_head  <= 5'd0;
            r_tail  <= 5'd0;
            r_count <= 6'd0;
        end else begin
            if (w_alloc_fire) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (commit_i) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_alloc_fire, commit_i})
                2'b10:   r_count <= r_count + 6'd1;
                2'b01:   r_count <= r_count - 6'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign alloc_fire_o = w_alloc_fire;
    assign head_o       = r_head;
    assign tail_o       = r_tail;
    assign full_o       = w_full;
    assign empty_o      = w_empty;

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocation at the tail, out-of-order writeback
// from ALU/LSU/MUL, in-order single retirement from the head.
// Build option: define ROB_COMMIT_BYPASS_EN to let a writeback that hits the
// head retire it in the same cycle; by default the head retires one cycle
// after its writeback is stored.
module rob #(
    parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
    parameter int XLEN      = rob_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            allocate_req_i,
    input  logic [4:0]      prd_addr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic [4:0]      rob_idx_o,
    input  logic            update_req_alu_i,
    input  logic            update_req_lsu_i,
    input  logic            update_req_mul_i,
    input  logic [31:0]     rob_idx_alu_i,
    input  logic [31:0]     rob_idx_lsu_i,
    input  logic [31:0]     rob_idx_mul_i,
    input  logic [XLEN-1:0] reg_value_alu_i,
    input  logic [XLEN-1:0] reg_value_lsu_i,
    input  logic [XLEN-1:0] reg_value_mul_i,
    output logic            empty_o,
    output logic            full_o,
    output logic            commitment_valid_o,
    output logic [XLEN-1:0] inst_committed_o,
    output logic [XLEN-1:0] pc_committed_o,
    output logic [4:0]      prd_addr_committed_o,
    output logic [XLEN-1:0] prd_value_committed_o
);
    import rob_pkg::*;

    // Status bits carry reset; payload arrays are rewritten on allocation.
    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_done;
    logic [XLEN-1:0]      r_pc    [ROB_DEPTH];
    logic [XLEN-1:0]      r_inst  [ROB_DEPTH];
    logic [4:0]           r_prd   [ROB_DEPTH];
    logic [XLEN-1:0]      r_value [ROB_DEPTH];

    logic [ROB_IDX_W-1:0] w_head;
    logic [ROB_IDX_W-1:0] w_tail;
    logic                 w_alloc_fire;
    logic                 w_commit;
    logic [ROB_IDX_W-1:0] w_idx_alu;
    logic [ROB_IDX_W-1:0] w_idx_lsu;
    logic [ROB_IDX_W-1:0] w_idx_mul;
    logic                 w_upd_alu;
    logic                 w_upd_lsu;
    logic                 w_upd_mul;
    logic                 w_fwd_hit;
    logic [XLEN-1:0]      w_fwd_value;
    rob_entry_t           w_head_entry;
    logic                 w_unused_idx_bits;

    rob_ptr_ctrl u_ptr_ctrl (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .alloc_req_i  (allocate_req_i),
        .commit_i     (w_commit),
        .alloc_fire_o (w_alloc_fire),
        .head_o       (w_head),
        .tail_o       (w_tail),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    // Only the low index bits address the buffer; the rest are don't-care.
    assign w_unused_idx_bits = ^{rob_idx_alu_i[31:ROB_IDX_W],
                                 rob_idx_lsu_i[31:ROB_IDX_W],
                                 rob_idx_mul_i[31:ROB_IDX_W]};

    // Writebacks only land on entries that are currently allocated.
    always_comb begin
        w_idx_alu = rob_idx_alu_i[ROB_IDX_W-1:0];
        w_idx_lsu = rob_idx_lsu_i[ROB_IDX_W-1:0];
        w_idx_mul = rob_idx_mul_i[ROB_IDX_W-1:0];
        w_upd_alu = update_req_alu_i & r_valid[w_idx_alu];
        w_upd_lsu = update_req_lsu_i & r_valid[w_idx_lsu];
        w_upd_mul = update_req_mul_i & r_valid[w_idx_mul];
    end

    // Same-cycle forwarding of a writeback that targets the head entry.
    always_comb begin
        w_fwd_hit   = 1'b0;
        w_fwd_value = {XLEN{1'b0}};
`ifdef ROB_COMMIT_BYPASS_EN
        if (w_upd_alu && (w_idx_alu == w_head)) begin
            w_fwd_hit   = 1'b1;
            w_fwd_value = reg_value_alu_i;
        end else if (w_upd_lsu && (w_idx_lsu == w_head)) begin
            w_fwd_hit   = 1'b1;
            w_fwd_value = reg_value_lsu_i;
        end else if (w_upd_mul && (w_idx_mul == w_head)) begin
            w_fwd_hit   = 1'b1;
            w_fwd_value = reg_value_mul_i;
        end else begin
            w_fwd_hit   = 1'b0;
            w_fwd_value = {XLEN{1'b0}};
        end
`endif
    end

    // Head entry view and retirement decision; outputs are zero when idle.
    always_comb begin
        w_head_entry.valid    = r_valid[w_head];
        w_head_entry.done     = r_done[w_head] | w_fwd_hit;
        w_head_entry.pc       = r_pc[w_head];
        w_head_entry.inst     = r_inst[w_head];
        w_head_entry.prd_addr = r_prd[w_head];
        w_head_entry.value    = w_fwd_hit ? w_fwd_value : r_value[w_head];
        w_commit              = w_head_entry.valid & w_head_entry.done;
        if (w_commit) begin
            pc_committed_o        = w_head_entry.pc;
            inst_committed_o      = w_head_entry.inst;
            prd_addr_committed_o  = w_head_entry.prd_addr;
            prd_value_committed_o = w_head_entry.value;
        end else begin
            pc_committed_o        = {XLEN{1'b0}};
            inst_committed_o      = {XLEN{1'b0}};
            prd_addr_committed_o  = 5'd0;
            prd_value_committed_o = {XLEN{1'b0}};
        end
    end

    assign commitment_valid_o = w_commit;
    assign rob_idx_o          = w_tail;

    // Entry status: allocate sets valid, writebacks set done (ALU last so it
    // wins), retirement clears the head; reset clears everything.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= {ROB_DEPTH{1'b0}};
            r_done  <= {ROB_DEPTH{1'b0}};
        end else begin
            if (w_alloc_fire) begin
                r_valid[w_tail] <= 1'b1;
                r_done[w_tail]  <= 1'b0;
            end
            if (w_upd_mul) begin
                r_done[w_idx_mul] <= 1'b1;
            end
            if (w_upd_lsu) begin
                r_done[w_idx_lsu] <= 1'b1;
            end
            if (w_upd_alu) begin
                r_done[w_idx_alu] <= 1'b1;
            end
            if (w_commit) begin
                r_valid[w_head] <= 1'b0;
                r_done[w_head]  <= 1'b0;
            end
        end
    end

    // Entry payload: written on allocation, value overwritten by writebacks
    // in MUL, LSU, ALU order so the highest-priority port lands last.
    always_ff @(posedge clk_i) begin
        if (w_alloc_fire) begin
            r_pc[w_tail]    <= pc_i;
            r_inst[w_tail]  <= inst_i;
            r_prd[w_tail]   <= prd_addr_i;
            r_value[w_tail] <= {XLEN{1'b0}};
        end
        if (w_upd_mul) begin
            r_value[w_idx_mul] <= reg_value_mul_i;
        end
        if (w_upd_lsu) begin
            r_value[w_idx_lsu] <= reg_value_lsu_i;
        end
        if (w_upd_alu) begin
            r_value[w_idx_alu] <= reg_value_alu_i;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: a queue-level reference model predicts status and
// retirements each cycle; a monitor on the falling edge pops and compares.
module tb_rob;

    logic        clk_i;
    logic        reset_i;
    logic        allocate_req_i;
    logic [4:0]  prd_addr_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [4:0]  rob_idx_o;
    logic        update_req_alu_i, update_req_lsu_i, update_req_mul_i;
    logic [31:0] rob_idx_alu_i, rob_idx_lsu_i, rob_idx_mul_i;
    logic [31:0] reg_value_alu_i, reg_value_lsu_i, reg_value_mul_i;
    logic        empty_o, full_o, commitment_valid_o;
    logic [31:0] inst_committed_o, pc_committed_o, prd_value_committed_o;
    logic [4:0]  prd_addr_committed_o;

    rob dut (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .allocate_req_i        (allocate_req_i),
        .prd_addr_i            (prd_addr_i),
        .pc_i                  (pc_i),
        .inst_i                (inst_i),
        .rob_idx_o             (rob_idx_o),
        .update_req_alu_i      (update_req_alu_i),
        .update_req_lsu_i      (update_req_lsu_i),
        .update_req_mul_i      (update_req_mul_i),
        .rob_idx_alu_i         (rob_idx_alu_i),
        .rob_idx_lsu_i         (rob_idx_lsu_i),
        .rob_idx_mul_i         (rob_idx_mul_i),
        .reg_value_alu_i       (reg_value_alu_i),
        .reg_value_lsu_i       (reg_value_lsu_i),
        .reg_value_mul_i       (reg_value_mul_i),
        .empty_o               (empty_o),
        .full_o                (full_o),
        .commitment_valid_o    (commitment_valid_o),
        .inst_committed_o      (inst_committed_o),
        .pc_committed_o        (pc_committed_o),
        .prd_addr_committed_o  (prd_addr_committed_o),
        .prd_value_committed_o (prd_value_committed_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  prd;
        logic [31:0] val;
    } commit_t;

    typedef struct {
        logic       empty;
        logic       full;
        logic [4:0] idx;
    } status_t;

    commit_t exp_q[$];
    status_t st_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: program-order list of in-flight slots plus slot data.
    int          order_q[$];
    bit          m_busy [32];
    bit          m_done [32];
    logic [31:0] m_pc   [32];
    logic [31:0] m_inst [32];
    logic [4:0]  m_prd  [32];
    logic [31:0] m_val  [32];
    int          m_next = 0;
    bit          known  = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endfunction

    // One clock of the model, using the inputs currently applied.
    function automatic void model_cycle();
        bit          ret;
        logic [31:0] rval;
        int          oldest;
        int          ia, il, im;
        ret    = 1'b0;
        rval   = 32'd0;
        oldest = (order_q.size() > 0) ? order_q[0] : -1;
        ia = int'(rob_idx_alu_i % 32);
        il = int'(rob_idx_lsu_i % 32);
        im = int'(rob_idx_mul_i % 32);
        if (oldest >= 0 && m_done[oldest]) begin
            ret  = 1'b1;
            rval = m_val[oldest];
        end
`ifdef ROB_COMMIT_BYPASS_EN
        if (oldest >= 0) begin
            if (update_req_alu_i && ia == oldest) begin ret = 1'b1; rval = reg_value_alu_i; end
            else if (update_req_lsu_i && il == oldest) begin ret = 1'b1; rval = reg_value_lsu_i; end
            else if (update_req_mul_i && im == oldest) begin ret = 1'b1; rval = reg_value_mul_i; end
        end
`endif
        if (known) begin
            st_q.push_back('{empty: (order_q.size() == 0), full: (order_q.size() == 32),
                             idx: 5'(m_next)});
            if (ret) exp_q.push_back('{pc: m_pc[oldest], inst: m_inst[oldest],
                                       prd: m_prd[oldest], val: rval});
        end
        if (reset_i) begin
            order_q.delete();
            for (int i = 0; i < 32; i++) begin m_busy[i] = 1'b0; m_done[i] = 1'b0; end
            m_next = 0;
            known  = 1'b1;
            return;
        end
        // Highest-priority writer decides the value of a shared target.
        if (update_req_alu_i && m_busy[ia]) begin m_done[ia] = 1'b1; m_val[ia] = reg_value_alu_i; end
        if (update_req_lsu_i && m_busy[il] && !(update_req_alu_i && ia == il)) begin
            m_done[il] = 1'b1; m_val[il] = reg_value_lsu_i;
        end
        if (update_req_mul_i && m_busy[im] && !(update_req_alu_i && ia == im)
            && !(update_req_lsu_i && il == im)) begin
            m_done[im] = 1'b1; m_val[im] = reg_value_mul_i;
        end
        if (allocate_req_i && order_q.size() < 32) begin
            m_busy[m_next] = 1'b1; m_done[m_next] = 1'b0;
            m_pc[m_next] = pc_i; m_inst[m_next] = inst_i; m_prd[m_next] = prd_addr_i;
            m_val[m_next] = 32'd0;
            order_q.push_back(m_next);
            m_next = (m_next + 1) % 32;
        end
        if (ret) begin
            m_busy[oldest] = 1'b0;
            m_done[oldest] = 1'b0;
            void'(order_q.pop_front());
        end
    endfunction

    task automatic idle_inputs();
        reset_i = 1'b0; allocate_req_i = 1'b0;
        prd_addr_i = 5'd0; pc_i = 32'd0; inst_i = 32'd0;
        update_req_alu_i = 1'b0; update_req_lsu_i = 1'b0; update_req_mul_i = 1'b0;
        rob_idx_alu_i = 32'd0; rob_idx_lsu_i = 32'd0; rob_idx_mul_i = 32'd0;
        reg_value_alu_i = 32'd0; reg_value_lsu_i = 32'd0; reg_value_mul_i = 32'd0;
    endtask

    // Predict this cycle, let the edge happen, then return to idle inputs.
    task automatic tick();
        model_cycle();
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] prd);
        allocate_req_i = 1'b1; pc_i = pc; inst_i = inst; prd_addr_i = prd;
        tick();
    endtask

    task automatic do_alu(input logic [31:0] idx, input logic [31:0] val);
        update_req_alu_i = 1'b1; rob_idx_alu_i = idx; reg_value_alu_i = val;
        tick();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
    endtask

    // Monitor: compare status every predicted cycle, and retirements.
    always @(negedge clk_i) begin
        status_t s;
        commit_t c;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("empty", 32'(empty_o), 32'(s.empty));
            chk("full", 32'(full_o), 32'(s.full));
            chk("rob_idx", 32'(rob_idx_o), 32'(s.idx));
            if (commitment_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    c = exp_q.pop_front();
                    chk("commit_pc", pc_committed_o, c.pc);
                    chk("commit_inst", inst_committed_o, c.inst);
                    chk("commit_prd", 32'(prd_addr_committed_o), 32'(c.prd));
                    chk("commit_value", prd_value_committed_o, c.val);
                end
            end else begin
                chk("commit_valid", 32'(commitment_valid_o), (exp_q.size() > 0) ? 32'd1 : 32'd0);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                chk("idle_outputs_zero",
                    pc_committed_o | inst_committed_o | prd_value_committed_o
                    | 32'(prd_addr_committed_o), 32'd0);
            end
        end
    end

    initial begin
        int          pend;
        logic [31:0] r;
        idle_inputs();
        // Reset and idle
        do_reset();
        do_reset();
        repeat (2) tick();
        // Single allocate / ALU writeback / retire
        do_alloc(32'h100, 32'h13, 5'd5);
        do_alu(32'd0, 32'hAB);
        repeat (3) tick();
        // Out-of-order completion, in-order retirement
        do_alloc(32'h200, 32'h1, 5'd1);
        do_alloc(32'h204, 32'h2, 5'd2);
        do_alloc(32'h208, 32'h3, 5'd3);
        do_alu(32'd3, 32'h22);
        do_alu(32'd2, 32'h11);
        tick();
        do_alu(32'd1, 32'h00);
        repeat (5) tick();
        // Fill to full, overflow, retire one while allocating, wrap
        do_reset();
        for (int i = 0; i < 32; i++) do_alloc(32'h1000 + 32'(4 * i), 32'(i), 5'(i));
        do_alloc(32'hDEAD, 32'hBEEF, 5'd31);
        allocate_req_i = 1'b1; pc_i = 32'hBAD; update_req_alu_i = 1'b1;
        rob_idx_alu_i = 32'd0; reg_value_alu_i = 32'h77;
        tick();
        allocate_req_i = 1'b1; pc_i = 32'hBAD0;
        tick();
        do_alloc(32'h5000, 32'h55, 5'd7);
        tick();
        // ALU and MUL racing on one entry
        do_reset();
        do_alloc(32'h300, 32'h33, 5'd3);
        update_req_alu_i = 1'b1; rob_idx_alu_i = 32'd0; reg_value_alu_i = 32'd1;
        update_req_mul_i = 1'b1; rob_idx_mul_i = 32'd0; reg_value_mul_i = 32'd2;
        tick();
        repeat (2) tick();
        // Reset with work in flight
        for (int i = 0; i < 4; i++) do_alloc(32'h400 + 32'(i), 32'(i), 5'(i + 8));
        do_alu(32'd1, 32'h9);
        do_reset();
        repeat (2) tick();
        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            allocate_req_i = ($urandom_range(0, 99) < 55);
            pc_i = $urandom(); inst_i = $urandom(); r = $urandom(); prd_addr_i = r[4:0];
            for (int p = 0; p < 3; p++) begin
                logic        req;
                logic [31:0] idx;
                req = ($urandom_range(0, 99) < 40);
                idx = $urandom() & 32'hFFFF_FFE0;
                pend = order_q.size();
                if (pend > 0 && $urandom_range(0, 9) < 7)
                    idx = idx | 32'(order_q[$urandom_range(0, pend - 1)]);
                else
                    idx = idx | 32'($urandom_range(0, 31));
                case (p)
                    0: begin update_req_alu_i = req; rob_idx_alu_i = idx; reg_value_alu_i = $urandom(); end
                    1: begin update_req_lsu_i = req; rob_idx_lsu_i = idx; reg_value_lsu_i = $urandom(); end
                    default: begin update_req_mul_i = req; rob_idx_mul_i = idx; reg_value_mul_i = $urandom(); end
                endcase
            end
            reset_i = ($urandom_range(0, 499) == 0);
            tick();
        end
        // Drain whatever is still in flight
        for (int n = 0; n < 80; n++) begin
            if (order_q.size() > 0) begin
                update_req_lsu_i = 1'b1;
                rob_idx_lsu_i = 32'(order_q[order_q.size() - 1]);
                reg_value_lsu_i = $urandom();
                update_req_alu_i = 1'b1;
                rob_idx_alu_i = 32'(order_q[0]);
                reg_value_alu_i = $urandom();
            end
            tick();
        end
        @(negedge clk_i);
        #1;
        chk("drained", 32'(order_q.size()), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
